// File: rtl/jogo_sequencia_unidade_controle_if.sv
// Control/status bundle between the sequence-game datapath and its control unit.
// master = datapath side (drives status), slave = control unit (drives strobes).
interface jogo_sequencia_unidade_controle_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimE;
    logic       fimL;
    logic       timeout;
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       zeraT;
    logic       contaT;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       db_timeout;
    logic [4:0] db_estado;

    modport master (
        output iniciar, jogada, igual, fimE, fimL, timeout,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
               pronto, acertou, errou, db_timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fimE, fimL, timeout,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
               pronto, acertou, errou, db_timeout, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_unidade_controle.sv
// Moore control unit for the memory-sequence game: sequences E/L counters,
// play register and play timer; all outputs decode the current state only.
module jogo_sequencia_unidade_controle #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    jogo_sequencia_unidade_controle_if.slave      bus
);

    typedef enum logic [4:0] {
        INICIAL        = 5'h00,
        PREPARACAO     = 5'h01,
        INICIA_RODADA  = 5'h02,
        ESPERA_JOGADA  = 5'h03,
        REGISTRA       = 5'h04,
        COMPARACAO     = 5'h05,
        PROXIMA_JOGADA = 5'h06,
        PROXIMA_RODADA = 5'h08,
        FIM_ACERTO     = 5'h0A,
        FIM_TIMEOUT    = 5'h0D,
        FIM_ERRO       = 5'h0E
    } estado_t;

    estado_t estado_q, estado_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d       = estado_q;
        bus.zeraE      = 1'b0;
        bus.contaE     = 1'b0;
        bus.zeraL      = 1'b0;
        bus.contaL     = 1'b0;
        bus.zeraR      = 1'b0;
        bus.registraR  = 1'b0;
        bus.zeraT      = 1'b0;
        bus.contaT     = 1'b0;
        bus.pronto     = 1'b0;
        bus.acertou    = 1'b0;
        bus.errou      = 1'b0;
        bus.db_timeout = 1'b0;
        bus.db_estado  = estado_q;

        case (estado_q)
            INICIAL: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
                bus.zeraT = 1'b1;
                if (bus.iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
                bus.zeraT = 1'b1;
                estado_d  = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                bus.zeraE = 1'b1;
                bus.zeraT = 1'b1;
                estado_d  = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                bus.contaT = TIMEOUT_EN;
                // a play arriving with the timeout still counts as a play
                if (bus.jogada)                     estado_d = REGISTRA;
                else if (bus.timeout && TIMEOUT_EN) estado_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                bus.registraR = 1'b1;
                bus.zeraT     = 1'b1;
                estado_d      = COMPARACAO;
            end
            COMPARACAO: begin
                if (!bus.igual)     estado_d = FIM_ERRO;
                else if (!bus.fimE) estado_d = PROXIMA_JOGADA;
                else if (bus.fimL)  estado_d = FIM_ACERTO;
                else                estado_d = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: begin
                bus.contaE = 1'b1;
                estado_d   = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                bus.contaL = 1'b1;
                estado_d   = INICIA_RODADA;
            end
            FIM_ACERTO: begin
                bus.pronto  = 1'b1;
                bus.acertou = 1'b1;
                if (bus.iniciar) estado_d = PREPARACAO;
            end
            FIM_ERRO: begin
                bus.pronto = 1'b1;
                bus.errou  = 1'b1;
                if (bus.iniciar) estado_d = PREPARACAO;
            end
            FIM_TIMEOUT: begin
                bus.pronto     = 1'b1;
                bus.errou      = 1'b1;
                bus.db_timeout = 1'b1;
                if (bus.iniciar) estado_d = PREPARACAO;
            end
            default: begin
                bus.db_estado = 5'b11111;
                estado_d      = INICIAL;
            end
        endcase
    end

endmodule

// File: tb/tb_jogo_sequencia_unidade_controle.sv
// Directed bench for the sequence-game control unit: vector table plus
// hand-written multi-cycle sequences against a small datapath counter model.
module tb_jogo_sequencia_unidade_controle;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    jogo_sequencia_unidade_controle_if bus ();
    jogo_sequencia_unidade_controle_if bus0 ();

    jogo_sequencia_unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    jogo_sequencia_unidade_controle #(.TIMEOUT_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0));

    int errors = 0;
    int checks = 0;

    // datapath model: E/L counters driven by the DUT strobes
    int e_cnt = 0, l_cnt = 0, n_contaL = 0, n_contaE = 0;
    logic use_model = 1'b0;
    logic tab_fimE = 1'b0, tab_fimL = 1'b0;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            e_cnt <= 0;
            l_cnt <= 0;
        end else begin
            if (bus.zeraE) e_cnt <= 0; else if (bus.contaE) e_cnt <= e_cnt + 1;
            if (bus.zeraL) l_cnt <= 0; else if (bus.contaL) l_cnt <= l_cnt + 1;
            if (bus.contaL) n_contaL <= n_contaL + 1;
            if (bus.contaE) n_contaE <= n_contaE + 1;
        end
    end
    assign bus.fimE = use_model ? (e_cnt == l_cnt) : tab_fimE;
    assign bus.fimL = use_model ? (l_cnt == 15)    : tab_fimL;

    // strobe order: zeraE contaE zeraL contaL zeraR registraR zeraT contaT
    //               pronto acertou errou db_timeout
    function automatic logic [11:0] exp_out(input logic [4:0] s, input bit te);
        case (s)
            5'h00, 5'h01: exp_out = 12'hAA0;
            5'h02:        exp_out = 12'h820;
            5'h03:        exp_out = te ? 12'h010 : 12'h000;
            5'h04:        exp_out = 12'h060;
            5'h06:        exp_out = 12'h400;
            5'h08:        exp_out = 12'h100;
            5'h0A:        exp_out = 12'h00C;
            5'h0E:        exp_out = 12'h00A;
            5'h0D:        exp_out = 12'h00B;
            default:      exp_out = 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] outs1();
        outs1 = {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR, bus.registraR,
                 bus.zeraT, bus.contaT, bus.pronto, bus.acertou, bus.errou, bus.db_timeout};
    endfunction

    function automatic logic [11:0] outs0();
        outs0 = {bus0.zeraE, bus0.contaE, bus0.zeraL, bus0.contaL, bus0.zeraR, bus0.registraR,
                 bus0.zeraT, bus0.contaT, bus0.pronto, bus0.acertou, bus0.errou, bus0.db_timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [4:0] s);
        chk({name, " db_estado"}, 32'(bus.db_estado), 32'(s));
        chk({name, " outputs"}, 32'(outs1()), 32'(exp_out(s, 1'b1)));
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input string name, input logic [4:0] s);
        int n = 0;
        while (bus.db_estado !== s && n < 60) begin
            cyc();
            n++;
        end
        if (bus.db_estado !== s) chk({name, " timeout waiting"}, 32'(bus.db_estado), 32'(s));
    endtask

    task automatic play(input string name, input logic ig);
        wait_state(name, 5'h03);
        bus.jogada = 1'b1;
        bus.igual  = ig;
        cyc();
        bus.jogada = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        cyc();
    endtask

    task automatic start_game();
        bus.iniciar = 1'b1;
        cyc();
        bus.iniciar = 1'b0;
    endtask

    typedef struct {
        logic       iniciar, jogada, igual, fimE, fimL, timeout;
        logic [4:0] exp_state;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic i, input logic j, input logic g, input logic fe,
                        input logic fl, input logic t, input logic [4:0] s);
        vec_t v;
        v.iniciar = i; v.jogada = j; v.igual = g; v.fimE = fe; v.fimL = fl; v.timeout = t;
        v.exp_state = s;
        vt.push_back(v);
    endtask

    initial begin
        bus.iniciar = 0; bus.jogada = 0; bus.igual = 0; bus.timeout = 0;
        bus0.iniciar = 0; bus0.jogada = 0; bus0.igual = 0; bus0.timeout = 0;
        bus0.fimE = 0; bus0.fimL = 0;

        #2;
        chk_state("reset", 5'h00);
        reset = 1'b0;

        //     ini jog ig fE fL to  state
        addv(0, 0, 0, 0, 0, 0, 5'h00);
        addv(1, 0, 0, 0, 0, 0, 5'h01);
        addv(1, 0, 0, 0, 0, 0, 5'h02);
        addv(1, 0, 0, 0, 0, 0, 5'h03);
        addv(1, 0, 0, 0, 0, 0, 5'h03);
        addv(0, 1, 0, 0, 0, 0, 5'h04);
        addv(0, 0, 0, 0, 0, 0, 5'h05);
        addv(0, 0, 1, 0, 0, 0, 5'h06);
        addv(0, 0, 1, 0, 0, 0, 5'h03);
        addv(0, 1, 1, 0, 0, 0, 5'h04);
        addv(0, 0, 1, 1, 0, 0, 5'h05);
        addv(0, 0, 1, 1, 0, 0, 5'h08);
        addv(0, 0, 0, 0, 0, 0, 5'h02);
        addv(0, 0, 0, 0, 0, 0, 5'h03);
        addv(0, 1, 0, 0, 0, 1, 5'h04);
        addv(0, 0, 0, 0, 0, 0, 5'h05);
        addv(0, 0, 0, 1, 1, 0, 5'h0E);
        addv(0, 0, 0, 0, 0, 0, 5'h0E);
        addv(1, 0, 0, 0, 0, 0, 5'h01);
        addv(0, 0, 0, 0, 0, 0, 5'h02);
        addv(0, 0, 0, 0, 0, 0, 5'h03);
        addv(0, 0, 0, 0, 0, 1, 5'h0D);
        addv(0, 0, 0, 0, 0, 0, 5'h0D);
        addv(1, 0, 0, 0, 0, 0, 5'h01);
        addv(0, 0, 0, 0, 0, 0, 5'h02);
        addv(0, 0, 0, 0, 0, 0, 5'h03);
        addv(0, 1, 1, 0, 0, 0, 5'h04);
        addv(0, 0, 1, 1, 1, 0, 5'h05);
        addv(0, 0, 1, 1, 1, 0, 5'h0A);
        addv(0, 0, 0, 0, 0, 0, 5'h0A);
        addv(1, 0, 0, 0, 0, 0, 5'h01);

        @(negedge clock);
        foreach (vt[k]) begin
            bus.iniciar = vt[k].iniciar; bus.jogada = vt[k].jogada; bus.igual = vt[k].igual;
            tab_fimE = vt[k].fimE; tab_fimL = vt[k].fimL; bus.timeout = vt[k].timeout;
            cyc();
            chk_state($sformatf("vec%0d", k), vt[k].exp_state);
        end
        bus.iniciar = 0; bus.jogada = 0; bus.timeout = 0;

        // full 16-round winning game driven by the counter model
        use_model = 1'b1;
        do_reset();
        n_contaL = 0;
        start_game();
        for (int r = 0; r <= 15; r++)
            for (int p = 0; p <= r; p++)
                play("win", 1'b1);
        wait_state("win end", 5'h0A);
        chk_state("win", 5'h0A);
        chk("win contaL pulses", 32'(n_contaL), 32'd15);

        // round L=2: first play correct, second wrong
        do_reset();
        start_game();
        for (int r = 0; r <= 1; r++)
            for (int p = 0; p <= r; p++)
                play("err", 1'b1);
        wait_state("err round2", 5'h03);
        n_contaE = 0;
        play("err p0", 1'b1);
        play("err p1", 1'b0);
        wait_state("err end", 5'h0E);
        chk_state("err", 5'h0E);
        chk("err contaE pulses", 32'(n_contaE), 32'd1);
        bus.igual = 1'b1;

        // restart from fim_erro skips inicial
        bus.iniciar = 1'b1;
        cyc();
        bus.iniciar = 1'b0;
        chk_state("restart", 5'h01);
        cyc();
        chk_state("restart", 5'h02);
        cyc();
        chk_state("restart", 5'h03);

        // reset asserted while in comparacao acts before the next clock
        bus.jogada = 1'b1;
        cyc();
        bus.jogada = 1'b0;
        cyc();
        chk_state("pre-reset", 5'h05);
        #2 reset = 1'b1;
        #1 chk_state("async reset", 5'h00);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc();
        chk_state("after reset", 5'h00);

        // TIMEOUT_EN=0: timeout ignored, contaT held low
        bus0.iniciar = 1'b1;
        cyc();
        bus0.iniciar = 1'b0;
        cyc();
        cyc();
        chk("te0 espera", 32'(bus0.db_estado), 32'h03);
        bus0.timeout = 1'b1;
        cyc();
        bus0.timeout = 1'b0;
        chk("te0 hold", 32'(bus0.db_estado), 32'h03);
        chk("te0 outputs", 32'(outs0()), 32'(exp_out(5'h03, 1'b0)));
        cyc();
        chk("te0 hold2", 32'(bus0.db_estado), 32'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
